// File: rtl/pcdec8_cl_if.sv
// ============================================================================
// pcdec8_cl_if : control/status bundle for one pcdec8_cl down-counter stage.
// Revision     : 1.0
// ============================================================================
`default_nettype none

interface pcdec8_cl_if #(
   parameter int WIDTH = 8
);
   logic             load;
   logic [WIDTH-1:0] din;
   logic             en;
   logic             hold;
   logic             bin;
   logic [WIDTH-1:0] cnt;
   logic             bout;
   logic             tc;

   modport master (
      output load, din, en, hold, bin,
      input  cnt, bout, tc
   );

   modport slave (
      input  load, din, en, hold, bin,
      output cnt, bout, tc
   );
endinterface

`default_nettype wire

// File: rtl/pcdec8_cl.sv
// ============================================================================
// pcdec8_cl : cascadable 8-bit loadable down-counter with borrow chain and
//             registered terminal-count pulse. Optional macro PCDEC8_RELOAD_EN
//             wraps from 0x00 to the last loaded value instead of 0xFF.
// Revision  : 1.0
// ============================================================================
`default_nettype none

module pcdec8_cl #(
   parameter int WIDTH = 8
) (
   input  wire logic        clk,
   input  wire logic        rst,
   pcdec8_cl_if.slave       bus
);

   logic [WIDTH-1:0] r_cnt;
   logic             r_tc;
   logic [WIDTH-1:0] w_wrap;
   logic             w_dec;
   logic             w_bout;

`ifdef PCDEC8_RELOAD_EN
   logic [WIDTH-1:0] r_reload;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_reload <= '0;
      end else if (bus.load) begin
         r_reload <= bus.din;
      end
   end

   assign w_wrap = r_reload;
`else
   assign w_wrap = '1;
`endif

   // Load masks the qualifier so the borrow chain never fires on a load cycle.
   assign w_dec  = bus.en & ~bus.hold & bus.bin & ~bus.load;
   assign w_bout = w_dec & (r_cnt == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
         r_tc  <= 1'b0;
      end else begin
         r_tc <= w_bout;
         if (bus.load) begin
            r_cnt <= bus.din;
         end else if (w_dec) begin
            r_cnt <= w_bout ? w_wrap : (r_cnt - 1'b1);
         end
      end
   end

   assign bus.cnt  = r_cnt;
   assign bus.tc   = r_tc;
   assign bus.bout = w_bout;

endmodule

`default_nettype wire

// File: tb/tb_pcdec8_cl.sv
// ============================================================================
// tb_pcdec8_cl : randomized and directed scoreboard bench for pcdec8_cl,
//                including a two-stage 16-bit cascade.
// Revision     : 1.0
// ============================================================================
`default_nettype none

module tb_pcdec8_cl;

`ifdef PCDEC8_RELOAD_EN
   localparam bit c_RELOAD = 1'b1;
`else
   localparam bit c_RELOAD = 1'b0;
`endif

   typedef struct {
      int unsigned cnt;
      int unsigned rel;
      bit          tc;
   } st_t;

   typedef struct {
      bit bout;
      bit cbout;
   } comb_t;

   typedef struct {
      int unsigned cnt;
      bit          tc;
      int unsigned c16;
      bit          ctc_lo;
      bit          ctc_hi;
   } seq_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   pcdec8_cl_if #(.WIDTH(8)) dif ();
   pcdec8_cl_if #(.WIDTH(8)) c_lo ();
   pcdec8_cl_if #(.WIDTH(8)) c_hi ();

   pcdec8_cl #(.WIDTH(8)) u_dut (.clk(clk), .rst(rst), .bus(dif.slave));
   pcdec8_cl #(.WIDTH(8)) u_lo  (.clk(clk), .rst(rst), .bus(c_lo.slave));
   pcdec8_cl #(.WIDTH(8)) u_hi  (.clk(clk), .rst(rst), .bus(c_hi.slave));

   assign c_hi.bin = c_lo.bout;

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   comb_t q_comb[$];
   seq_t  q_seq[$];

   st_t m_main = '{cnt: 0, rel: 0, tc: 1'b0};
   st_t m_lo   = '{cnt: 0, rel: 0, tc: 1'b0};
   st_t m_hi   = '{cnt: 0, rel: 0, tc: 1'b0};

   task automatic chk(input string name, input int unsigned act, input int unsigned exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // One stage of the reference: a down-counter value in 0..255 with wrap target.
   function automatic st_t step(input st_t s, input bit r, input bit ld,
                                input int unsigned d, input bit dec, output bit bout);
      st_t n = s;
      bout = dec && (s.cnt == 0);
      if (r) begin
         n.cnt = 0;
         n.rel = 0;
         n.tc  = 1'b0;
      end else begin
         n.tc = bout;
         if (ld) begin
            n.cnt = d;
            n.rel = d;
         end else if (dec) begin
            n.cnt = (s.cnt == 0) ? (c_RELOAD ? s.rel : 255) : s.cnt - 1;
         end
      end
      return n;
   endfunction

   // Drive one cycle of inputs on the falling edge and queue the expectations.
   task automatic drive(input bit r, input bit ld, input int unsigned d, input bit e,
                        input bit h, input bit b, input bit cld, input int unsigned cd,
                        input bit ce);
      comb_t c;
      seq_t  s;
      bit    bo, lbo, hbo;
      @(negedge clk);
      rst       = r;
      dif.load  = ld;
      dif.din   = d[7:0];
      dif.en    = e;
      dif.hold  = h;
      dif.bin   = b;
      c_lo.load = cld;
      c_lo.din  = cd[7:0];
      c_lo.en   = ce;
      c_lo.hold = 1'b0;
      c_lo.bin  = 1'b1;
      c_hi.load = cld;
      c_hi.din  = cd[15:8];
      c_hi.en   = ce;
      c_hi.hold = 1'b0;
      m_main = step(m_main, r, ld, d[7:0], e && !h && b && !ld, bo);
      m_hi   = step(m_hi, r, cld, cd[15:8], ce && !cld && (m_lo.cnt == 0), hbo);
      m_lo   = step(m_lo, r, cld, cd[7:0], ce && !cld, lbo);
      c.bout  = bo;
      c.cbout = lbo;
      q_comb.push_back(c);
      s.cnt    = m_main.cnt;
      s.tc     = m_main.tc;
      s.c16    = m_hi.cnt * 256 + m_lo.cnt;
      s.ctc_lo = m_lo.tc;
      s.ctc_hi = m_hi.tc;
      q_seq.push_back(s);
   endtask

   task automatic mcyc(input bit r, input bit ld, input int unsigned d,
                       input bit e, input bit h, input bit b);
      drive(r, ld, d, e, h, b, 1'b0, 0, 1'b0);
   endtask

   // Combinational borrow is sampled mid-low-phase, after inputs settle.
   always @(negedge clk) begin
      comb_t c;
      #3;
      if (q_comb.size() > 0) begin
         c = q_comb.pop_front();
         chk("bout", dif.bout, c.bout);
         chk("casc_bout", c_lo.bout, c.cbout);
      end
   end

   always @(posedge clk) begin
      seq_t s;
      #1;
      if (q_seq.size() > 0) begin
         s = q_seq.pop_front();
         chk("cnt", dif.cnt, s.cnt);
         chk("tc", dif.tc, s.tc);
         chk("casc_cnt16", {c_hi.cnt, c_lo.cnt}, s.c16);
         chk("casc_tc_lo", c_lo.tc, s.ctc_lo);
         chk("casc_tc_hi", c_hi.tc, s.ctc_hi);
      end
   end

   initial begin
      dif.load = 1'b0; dif.din = '0; dif.en = 1'b0; dif.hold = 1'b0; dif.bin = 1'b0;
      c_lo.load = 1'b0; c_lo.din = '0; c_lo.en = 1'b0; c_lo.hold = 1'b0; c_lo.bin = 1'b1;
      c_hi.load = 1'b0; c_hi.din = '0; c_hi.en = 1'b0; c_hi.hold = 1'b0;

      // Reset with a competing load, then idle with en low.
      repeat (2) mcyc(1, 1, 8'h5A, 1, 0, 1);
      repeat (3) mcyc(0, 0, 0, 0, 0, 1);

      // Load 3 and count through the wrap.
      mcyc(0, 1, 8'h03, 0, 0, 0);
      repeat (5) mcyc(0, 0, 0, 1, 0, 1);

      // Hold and borrow gating at 0x10.
      mcyc(0, 1, 8'h10, 0, 0, 0);
      repeat (3) mcyc(0, 0, 0, 1, 1, 1);
      repeat (3) mcyc(0, 0, 0, 1, 0, 0);
      repeat (3) mcyc(0, 0, 0, 1, 0, 1);

      // Load beats a borrow at zero.
      mcyc(0, 1, 8'h00, 0, 0, 0);
      mcyc(0, 1, 8'h80, 1, 0, 1);
      mcyc(0, 0, 0, 0, 0, 1);

      // Two-stage cascade: load 0x0100, single decrement, then a short run.
      drive(0, 0, 0, 0, 0, 0, 1, 16'h0100, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 1, 16'h0001, 0);
      repeat (3) drive(0, 0, 0, 0, 0, 0, 0, 0, 1);

      // Reset in the middle of a count suppresses the pending pulse.
      mcyc(0, 1, 8'h01, 0, 0, 0);
      mcyc(0, 0, 0, 1, 0, 1);
      mcyc(1, 0, 0, 1, 0, 1);
      repeat (2) mcyc(0, 0, 0, 0, 0, 1);

      // Randomized traffic on all stages.
      for (int i = 0; i < 600; i++) begin
         drive(($urandom_range(0, 99) < 2),
               ($urandom_range(0, 99) < 8), $urandom_range(0, 12),
               ($urandom_range(0, 99) < 85), ($urandom_range(0, 99) < 15),
               ($urandom_range(0, 99) < 85),
               ($urandom_range(0, 99) < 4), $urandom_range(0, 700),
               ($urandom_range(0, 99) < 90));
      end

      mcyc(0, 0, 0, 0, 0, 1);
      @(negedge clk);
      @(negedge clk);
      chk("queues_drained", q_comb.size() + q_seq.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/pcdec8_cl.md
# pcdec8_cl

Cascadable 8-bit synchronous down-counter, loadable, with hold, borrow chaining and a registered terminal-count flag. It is the decrementing counterpart of the 8-bit loadable up-counter with carry chain in the same counter family. Stages chain through borrow-out to borrow-in to form wider down-counters. Typical uses are timers, delay generators and programmable dividers.

## Interface
Parameters:
- `WIDTH`, 8: counter width. Only 8 is supported and verified.

Ports:
- `clk` input 1: the single clock. All state updates on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `load` input 1: parallel load strobe. Highest priority after `rst`.
- `din` input 8: parallel load value.
- `en` input 1: count enable.
- `hold` input 1: count inhibit. When high, blocks decrement even if `en` is high.
- `bin` input 1: borrow-in from the lower stage. Tie to 1 on the least-significant stage.
- `cnt` output 8: registered counter value.
- `bout` output 1: combinational borrow-out to the next stage.
- `tc` output 1: registered terminal-count pulse.

## Operation
- Decrement qualifier: `dec = en & ~hold & bin & ~load`.
- Borrow-out: `bout = dec & (cnt == 8'h00)`. Purely combinational. The chain ripples across stages in one cycle.
- Next-state priority, highest first:
  1. `rst`: `cnt` becomes 0x00 and `tc` becomes 0.
  2. `load`: `cnt` becomes `din`. `tc` becomes 0. `en`, `hold` and `bin` are ignored.
  3. `dec`: `cnt` becomes `cnt - 1` modulo 256. When `cnt` was 0x00, the new value is the wrap value (see Configuration).
  4. Otherwise `cnt` holds.
- `tc` is 1 for exactly one cycle after any cycle in which `bout` was 1. Otherwise it is 0.
- Arithmetic is unsigned 8-bit. There are no saturating modes.
- `hold` and `en` are level-sensitive. Deasserting either in the middle of a count freezes `cnt` with no side effects.
- If `load` and `dec` conditions occur in the same cycle, load wins. `bout` is 0 in that cycle because `dec` includes `~load`.
- If `rst` is asserted in the middle of an operation, it overrides everything on the next edge. Any pending `tc` is cleared.

## Timing
- Reset values: `cnt` = 0x00, `tc` = 0, reload register = 0x00 (macro builds only). While `cnt` = 0x00, `bout` = `dec`.
- Load latency is one cycle: `cnt` equals `din` at the first edge after `load` is sampled high.
- Decrement latency is one cycle per qualified edge.
- `tc` follows the wrapping edge by zero cycles: it is registered alongside `cnt` on the same edge. It is high during the cycle in which `cnt` first shows the wrap value.
- `bout` is valid in the same cycle as its inputs. The combinational path `bin` → `bout` must meet timing through 4 cascaded stages.
- A period of N+1 qualified decrements from a load of N returns `cnt` to the wrap value, giving one `tc` pulse per period.

## Configuration
Macro: `PCDEC8_RELOAD_EN`.
- Defined:
  - An 8-bit reload register captures `din` on every `load`. It is cleared by `rst`.
  - On decrement from 0x00, `cnt` takes the reload value instead of 0xFF.
  - The stage therefore acts as a divide-by-(reload+1) counter.
- Undefined:
  - No reload register is built.
  - Decrement from 0x00 wraps to 0xFF.

## Test plan
- Reset: assert `rst` for 2 cycles with `load`=1 and `din`=0x5A → `cnt`=0x00 and `tc`=0 after release. `cnt` stays 0x00 while `en`=0.
- Load and count: `load` with `din`=0x03, then `en`=1, `bin`=1 for 4 cycles.
  - `cnt` sequence: 0x03, 0x02, 0x01, 0x00, then the wrap value.
  - Wrap value is 0xFF without the macro, or 0x03 with the macro.
  - `bout`=1 only in the cycle where `cnt`=0x00.
  - `tc`=1 for one cycle coinciding with the wrap value.
- Hold and borrow gating: at `cnt`=0x10, test three cases for 3 cycles each.
  - `en`=1, `hold`=1 → `cnt` stays 0x10.
  - `hold`=0, `bin`=0 → `cnt` stays 0x10.
  - `bin`=1 → `cnt` reaches 0x0D after 3 cycles.
- Load priority: at `cnt`=0x00 with `en`=`bin`=1, assert `load` with `din`=0x80 → `bout`=0 in that cycle, `cnt`=0x80 next cycle, `tc`=0.
- Cascade: build two stages as a 16-bit counter, load 0x0100 and decrement once.
  - Expect 0x00FF: the low stage wraps to 0xFF (non-macro build), and the high stage goes from 0x01 to 0x00 via the `bout`→`bin` link.
  - `tc` pulses only in the low stage.
- Reset mid-count: at `cnt`=0x01 with `en`=1, assert `rst` → `cnt`=0x00, `tc`=0, and no `tc` pulse is produced.
